// File: rtl/slt_minmax_tracker.sv
// Streaming signed min/max/count reducer over a valid/ready block interface.
// Holds the block result in DONE until the consumer takes it.

module slt #(
    parameter int N = 32
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic                lt
);
    assign lt = (a < b);
endmodule

module slt_minmax_tracker #(
    parameter int N       = 32,
    parameter int COUNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [N-1:0]   out_min,
    output logic signed [N-1:0]   out_max,
    output logic [COUNT_W-1:0]    out_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic signed [N-1:0]   min_q;
    logic signed [N-1:0]   max_q;
    logic [COUNT_W-1:0]    count_q;
    logic                  lt_min;
    logic                  gt_max;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        if (&c)
            sat_inc = c;
        else
            sat_inc = c + COUNT_W'(1);
    endfunction

    slt #(.N(N)) u_slt_min (.a(in_data), .b(min_q),   .lt(lt_min));
    slt #(.N(N)) u_slt_max (.a(max_q),   .b(in_data), .lt(gt_max));

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
        end else if (clr) begin
            // clr wins over accept and transfer; a sample offered now is dropped
            state_q <= EMPTY;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        min_q   <= in_data;
                        max_q   <= in_data;
                        count_q <= COUNT_W'(1);
                        state_q <= in_last ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (lt_min) min_q <= in_data;
                        if (gt_max) max_q <= in_data;
                        count_q <= sat_inc(count_q);
                        if (in_last) state_q <= DONE;
                    end
                end
                DONE: begin
                    // registers are kept; next first accept overwrites them
                    if (out_ready) state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/slt_minmax_tracker.md
# slt_minmax_tracker

Streaming signed min/max reducer that sits directly downstream of the `slt` comparator and instantiates two copies of it. It accepts a block of signed N-bit samples over a valid/ready handshake and tracks the running minimum, maximum and sample count. It then presents the block result on an output valid/ready handshake. It is the first sequential consumer of `slt` in the datapath and uses `slt`'s signed less-than semantics unchanged.

## Interface
- `N`, 32: sample width in bits; samples are two's-complement signed.
- `COUNT_W`, 8: width of the sample counter.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `clr`  input  1  synchronous clear; abandons the current block.
- `in_valid`  input  1  `in_data` and `in_last` are valid.
- `in_ready`  output  1  block can accept a sample this cycle.
- `in_data`  input  N  signed sample.
- `in_last`  input  1  marks the final sample of a block.
- `out_valid`  output  1  block result is valid and held.
- `out_ready`  input  1  consumer takes the result.
- `out_min`  output  N  signed minimum of the block.
- `out_max`  output  N  signed maximum of the block.
- `out_count`  output  COUNT_W  number of samples in the block, saturating.

## Operation
- **Comparators:** two `slt` instances.
  - `lt_min = slt(a=in_data, b=min_q)`.
  - `gt_max = slt(a=max_q, b=in_data)`.
  - Comparison is signed, so 0x80000000 < 0x7FFFFFFF for N=32.
- **FSM states:** `EMPTY` (no sample in block), `ACCUM` (at least one sample held), `DONE` (result held).
- `in_ready` = 1 in `EMPTY` and `ACCUM`, 0 in `DONE`; decoded combinationally from state.
- `out_valid` = 1 only in `DONE`; decoded from state.
- An accept occurs when `in_valid & in_ready`.
- **Accept in `EMPTY`:** `min_q` ← `in_data`, `max_q` ← `in_data`, `count_q` ← 1. The next state is `DONE` if `in_last`, else `ACCUM`.
- **Accept in `ACCUM`:**
  - If `lt_min`, `min_q` ← `in_data`.
  - If `gt_max`, `max_q` ← `in_data`.
  - Both updates can occur in the same cycle only in theory; with min ≤ max at most one fires.
  - Equal values cause no update.
  - `count_q` ← `count_q`+1, saturating at 2^COUNT_W−1.
  - `in_last` moves the FSM to `DONE`.
- **No accept:** state and registers are unchanged.
- **`DONE`:** `out_min`/`out_max`/`out_count` drive `min_q`/`max_q`/`count_q` and are stable while `out_valid` and `!out_ready`.
  - `out_valid & out_ready` → `EMPTY`.
  - The registers keep their values; they are overwritten on the next first accept.
- **`clr` = 1:** next state is `EMPTY` and `min_q`/`max_q`/`count_q` ← 0.
  - `clr` has priority over accept and over output transfer.
  - A sample presented in that cycle is considered accepted (`in_ready` was high) but is discarded.
- **`rst` = 1:** asynchronously forces state `EMPTY` and `min_q`/`max_q`/`count_q` = 0. Hence after reset `out_valid`=0, `in_ready`=1 and the outputs are 0. This holds mid-block and while in `DONE`.

## Timing
- Result latency: `out_valid` rises on the clock edge that accepts the `in_last` sample, so it is visible 1 cycle after that accept.
- **Throughput:** one sample per cycle while in `EMPTY`/`ACCUM`.
- One bubble: in the cycle after a result transfer, the FSM is in `EMPTY` and can accept immediately. A new sample cannot be accepted in the same cycle as the transfer because `in_ready`=0 in `DONE`.
- A single-sample block (`in_last` on the first sample) reaches `DONE` in 1 cycle with min = max = sample and count = 1.
- No combinational path from `out_ready` or `in_valid` to `in_ready`/`out_valid`.
- `slt` is combinational; its path through the compare to the `min_q`/`max_q` enables must close in one cycle.

## Test plan
- **Reset mid-block:** after 3 accepts, pulse `rst` asynchronously between edges → `out_valid`=0, `in_ready`=1, `out_min`/`out_max`/`out_count` = 0 immediately. The next block starts fresh.
- **Signed ordering:**
  - Block {5, −1, 0x7FFFFFFF, 0x80000000(last)} → `out_min`=0x80000000, `out_max`=0x7FFFFFFF, `out_count`=4.
  - `out_valid` is seen 1 cycle after the last accept.
- **Single sample and equality:**
  - Block {−7(last)} → min = max = −7, count = 1.
  - Block {3, 3, 3(last)} → min = max = 3, count = 3.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles in `DONE` → outputs stable, `in_ready`=0, `in_valid` ignored.
  - Raise `out_ready` → `EMPTY` next cycle.
  - Back-to-back blocks each produce correct independent results.
- **Clear and saturation:**
  - `clr` asserted with `in_valid` on the 2nd sample → state `EMPTY`, registers 0, and that sample is absent from the next result.
  - With `COUNT_W`=4, a 20-sample block → `out_count`=15.
- **Random:** 100 blocks of random length 1–10 with `$random` data and random `out_ready` stalls. A behavioural signed min/max/count model is compared with `===` on every output transfer, and the error count is reported.
